accum_seq_ctrl: RTL
===================

# accum_seq_ctrl

Job sequencer for the 8-bit accumulator datapath. It accepts a job command (operand count), clears the accumulator, and streams exactly that many operands into it over a valid/ready handshake. It records sticky carry and signed-overflow flags across the job, then pulses `done` with the final result. It sits between an operand producer (switch/FIFO front end) and the display/result consumer, replacing free-running accumulation with bounded, restartable jobs.

## Interface
- `W`, 8, operand/accumulator width in bits
- `CNT_W`, 8, width of the job length and beat counter

- `clk`  in  1  clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  job request; sampled only in IDLE
- `len`  in  CNT_W  operand count for the job, captured on accepted `start`; 0 is legal
- `in_data`  in  W  operand
- `in_valid`  in  1  operand valid
- `in_ready`  out  1  operand accepted when `in_valid & in_ready`
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle pulse at job completion
- `result`  out  W  accumulator value; holds after `done` until next accepted `start`
- `carry`  out  1  sticky OR of unsigned carry-out over the job
- `ovf`  out  1  sticky OR of signed overflow over the job
- `beats`  out  CNT_W  operands accepted so far in current/last job

## Operation
- States: IDLE, RUN, DONE. Encoded as a package enum.
- **IDLE** (`start` = 1):
  - Capture `len`.
  - Clear `result`, `carry`, `ovf` and `beats` to 0.
  - Go to RUN if `len` != 0, otherwise go to DONE.
- **IDLE** (`start` = 0): stay.
- **RUN**: `in_ready` = 1. On each handshake:
  - `result` <= `result` + `in_data` (mod 2^W).
  - `beats` <= `beats` + 1.
  - Flags update.
  - When the beat that makes `beats` == `len` is accepted, go to DONE.
- **DONE**: `done` = 1 and `in_ready` = 0 for exactly one cycle, then go to IDLE unconditionally.
- Arithmetic, with `s` = `result` and `a` = `in_data`:
  - Raw sum `sum_d` = `s` + `a` is W+1 bits wide.
  - `c_d` = `sum_d[W]`.
  - `v_d` = (`s[W-1]` == `a[W-1]`) & (`sum_d[W-1]` != `s[W-1]`).
  - `carry` <= `carry` | `c_d` and `ovf` <= `ovf` | `v_d`, updated on handshake beats only.
- No handshake in RUN (`in_valid` = 0): all state holds; there is no timeout.
- `start` while `busy`: ignored, including the DONE cycle. There is no queueing.
- `len` and `start` changes after capture have no effect on the running job.
- `in_valid` outside RUN: ignored, since `in_ready` = 0.
- `len` = 2^CNT_W − 1 is supported; `beats` never wraps within a job.
- Reset, asynchronous and at any time including mid-RUN:
  - State returns to IDLE.
  - `result` = 0, `carry` = 0, `ovf` = 0, `beats` = 0.
  - `in_ready` = 0, `busy` = 0, `done` = 0.
  - A partially accumulated job is discarded.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Start accepted at edge T:
  - `busy` is high from T+1.
  - `in_ready` is high from T+1 when `len` != 0.
- Operand accepted at edge T: `result`, the flags and `beats` reflect it after T, i.e. one cycle of latency.
- Last operand accepted at edge T: `done` is high during the cycle following T, `busy` falls after T+1, and a new `start` is accepted at T+2 at the earliest.
- `len` = 0, `start` at edge T: `done` is high in the cycle after T, with `result` = 0.
- Throughput: one operand per cycle while `in_valid` stays high.

## Configuration
- `ACC_SAT_EN` defined:
  - On a beat with `v_d` = 1, `result` saturates instead of wrapping.
  - It becomes 2^(W−1)−1 (0x7F) when `a[W-1]` = 0, and −2^(W−1) (0x80) when `a[W-1]` = 1.
  - `ovf` and `carry` are still set from the raw sum.
  - Later beats add to the saturated value.
- `ACC_SAT_EN` undefined: `result` wraps mod 2^W. All flag behaviour is identical.

## Structure
- Shared package `accum_pkg`:
  - State enum `acc_state_t` (IDLE, RUN, DONE).
  - Default `ACC_W` = 8.
  - Saturation constants `ACC_SAT_MAX` and `ACC_SAT_MIN`, derived from the width.
- Sub-module `acc_core`:
  - Inputs: `clk`, `reset_n`, `clr`, `en`, `a`.
  - Outputs: `sum`, `c_d`, `v_d`.
  - Owns the W-bit adder, the result register, the overflow detection and the optional saturation.
- `accum_seq_ctrl` owns the FSM, the beat counter, the sticky flags and the handshake, and drives `clr` and `en`.

## Test plan
- `len` = 3; operands 10, 20, 30 with `in_valid` held high → `result` = 60, `carry` = 0, `ovf` = 0, `beats` = 3, `done` one cycle after the third beat.
- `len` = 2; operands 100, 100 → without the macro: `result` = 0xC8, `ovf` = 1, `carry` = 0. With `ACC_SAT_EN`: `result` = 0x7F, `ovf` = 1.
- `len` = 2; operands 0xFF, 0x02 → `result` = 0x01, `carry` = 1, `ovf` = 0. Also: operands 0x80, 0xFF → `ovf` = 1, `carry` = 1; `result` = 0x7F without the macro, 0x80 with `ACC_SAT_EN`.
- `len` = 0 → `done` in the cycle after the start edge, `result` = 0, no `in_ready` cycle.
- `len` = 4 with `in_valid` gaps, plus `start` pulsed mid-job and during `done` → `start` ignored, exactly 4 beats summed, a single `done` pulse.
- Assert `reset_n` low after 1 of 3 beats → all outputs 0 immediately. After release, a new `len` = 1 job with operand 5 → `result` = 5, `done`.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator job sequencer.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    localparam int ACC_W = 8;

    localparam logic [ACC_W-1:0] ACC_SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Two's-complement overflow: same-sign operands yielding a different-sign sum.
    function automatic logic add_ovf(input logic s_msb, input logic a_msb, input logic sum_msb);
        return (s_msb == a_msb) && (sum_msb != s_msb);
    endfunction

endpackage

// File: rtl/acc_core.sv
// Accumulator datapath: W-bit adder, result register, carry/overflow detect.
// Optional saturation on signed overflow when ACC_SAT_EN is defined.
module acc_core
    import accum_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] a,
    output logic [W-1:0] sum,
    output logic         c_d,
    output logic         v_d
);

`ifdef ACC_SAT_EN
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
`endif

    logic [W:0]   sum_d_s;
    logic [W-1:0] sum_r;
    logic [W-1:0] next_sum_s;

    // Raw W+1-bit sum and the flags derived from it
    always_comb begin
        sum_d_s = {1'b0, sum_r} + {1'b0, a};
        c_d     = sum_d_s[W];
        v_d     = add_ovf(sum_r[W-1], a[W-1], sum_d_s[W-1]);
    end

    // Select the value written back: wrapped sum, or clamped on overflow
    always_comb begin
        next_sum_s = sum_d_s[W-1:0];
`ifdef ACC_SAT_EN
        if (v_d) begin
            if (a[W-1]) begin
                next_sum_s = SAT_MIN;
            end else begin
                next_sum_s = SAT_MAX;
            end
        end else begin
            next_sum_s = sum_d_s[W-1:0];
        end
`endif
    end

    // Result register: clear wins over accumulate
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_r <= {W{1'b0}};
        end else if (clr) begin
            sum_r <= {W{1'b0}};
        end else if (en) begin
            sum_r <= next_sum_s;
        end
    end

    assign sum = sum_r;

endmodule

// File: rtl/accum_seq_ctrl.sv
// Job sequencer: accepts a length, streams that many operands into acc_core,
// tracks sticky carry/overflow and pulses done. Build macro: ACC_SAT_EN.
module accum_seq_ctrl
    import accum_pkg::*;
#(
    parameter int W     = ACC_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic             carry,
    output logic             ovf,
    output logic [CNT_W-1:0] beats
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    acc_state_t       state_r;
    acc_state_t       state_nxt_s;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] beats_r;
    logic             carry_r;
    logic             ovf_r;
    logic             clr_s;
    logic             hs_s;
    logic             last_beat_s;
    logic             c_d_s;
    logic             v_d_s;

    assign clr_s       = (state_r == IDLE) && start;
    assign hs_s        = (state_r == RUN) && in_valid;
    // len_r is non-zero whenever RUN is entered, so len_r - 1 cannot underflow here
    assign last_beat_s = hs_s && (beats_r == (len_r - CNT_ONE));

    acc_core #(.W(W)) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_s),
        .en      (hs_s),
        .a       (in_data),
        .sum     (result),
        .c_d     (c_d_s),
        .v_d     (v_d_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len == {CNT_W{1'b0}}) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_beat_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b0;
                busy     = 1'b0;
                done     = 1'b0;
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                done     = 1'b0;
            end
            DONE: begin
                in_ready = 1'b0;
                busy     = 1'b1;
                done     = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
                done     = 1'b0;
            end
        endcase
    end

    // Job length capture, beat counter and sticky flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_r   <= {CNT_W{1'b0}};
            beats_r <= {CNT_W{1'b0}};
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (clr_s) begin
            len_r   <= len;
            beats_r <= {CNT_W{1'b0}};
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (hs_s) begin
            beats_r <= beats_r + CNT_ONE;
            carry_r <= carry_r | c_d_s;
            ovf_r   <= ovf_r | v_d_s;
        end
    end

    assign carry = carry_r;
    assign ovf   = ovf_r;
    assign beats = beats_r;

endmodule
